// File: rtl/cf_pkg.sv
// Shared constants and types for the control-flow controller:
// opcodes it resolves, PC mux select encoding and FSM states.
package cf_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      PC_SEQ   = 2'b00,
      PC_BRADD = 2'b01,
      PC_ALU   = 2'b10,
      PC_TRAP  = 2'b11
   } pc_sel_t;

   typedef enum logic {
      CF_RUN     = 1'b0,
      CF_JALR_EX = 1'b1
   } cf_state_t;

endpackage

// File: rtl/cf_decode.sv
// ID-stage control-flow decode: classifies the instruction in ID as JAL,
// JALR or a taken conditional branch. A bubble (valid low) decodes as
// nothing regardless of its opcode bits.
module cf_decode
   import cf_pkg::*;
(
   input  logic [31:0] instruction_id_i,
   input  logic        instruction_id_valid_i,
   input  logic        branch_condition_i,
   output logic        jal_id,
   output logic        jalr_id,
   output logic        br_taken
);

   logic [6:0] opcode;
   logic       br_id;
   logic       unused_instr_bits;

   assign opcode = instruction_id_i[6:0];

   // Opcode match, gated by the ID valid bit; funct3[0] inverts the
   // comparator result so BNE/BGE/BGEU reuse the eq/lt/ltu comparator.
   always_comb begin
      jal_id   = instruction_id_valid_i && (opcode == OPC_JAL);
      jalr_id  = instruction_id_valid_i && (opcode == OPC_JALR);
      br_id    = instruction_id_valid_i && (opcode == OPC_BRANCH);
      br_taken = br_id && (instruction_id_i[12] ^ branch_condition_i);
   end

   assign unused_instr_bits = ^{instruction_id_i[31:13], instruction_id_i[11:7]};

endmodule

// File: rtl/control_flow_ctrl.sv
// Control-flow controller for the 5-stage pipeline: picks the next PC,
// resolves JAL/branches in ID and JALR in EX (one cycle later), and
// drives IF/ID and ID/EX flushes.
// Optional feature: define CF_MISALIGN_TRAP_EN to redirect misaligned
// jump/branch targets to TRAP_VECTOR and expose misalign_o.
module control_flow_ctrl
   import cf_pkg::*;
#(
`ifdef CF_MISALIGN_TRAP_EN
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
`endif
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction_id_i,
   input  logic        instruction_id_valid_i,
   input  logic        branch_condition_i,
   input  logic [31:0] branch_adder_id_i,
   input  logic [31:0] alu_result_ex_i,
   input  logic [31:0] pc_plus4_if_i,
   input  logic        stall_i,
   output logic [31:0] pc_next_if_o,
   output logic [1:0]  pc_sel_o,
   output logic        pc_en_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
`ifdef CF_MISALIGN_TRAP_EN
   output logic        misalign_o,
`endif
   output logic        jalr_pending_o
);

   cf_state_t   state;
   pc_sel_t     pc_sel;
   logic        jal_id;
   logic        jalr_id;
   logic        br_taken;
   logic [31:0] jalr_target;
   logic        misalign;
   logic        unused_alu_bit;

   cf_decode u_decode (
      .instruction_id_i       (instruction_id_i),
      .instruction_id_valid_i (instruction_id_valid_i),
      .branch_condition_i     (branch_condition_i),
      .jal_id                 (jal_id),
      .jalr_id                (jalr_id),
      .br_taken               (br_taken)
   );

   assign jalr_target    = {alu_result_ex_i[31:1], 1'b0};
   assign unused_alu_bit = alu_result_ex_i[0];

   // FSM: a JALR in ID arms a one-cycle wait for its EX-stage target,
   // unless the pipeline is stalled (rs1 not ready yet).
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= CF_RUN;
      end else begin
         case (state)
            CF_RUN:     if (!stall_i && jalr_id) state <= CF_JALR_EX;
            CF_JALR_EX: state <= CF_RUN;
            default:    state <= CF_RUN;
         endcase
      end
   end

   // Next-PC mux and flush generation; reset forces RESET_PC and no redirect,
   // and an armed JALR overrides anything currently in ID.
   always_comb begin
      pc_sel        = PC_SEQ;
      pc_next_if_o  = pc_plus4_if_i;
      pc_en_o       = 1'b0;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      misalign      = 1'b0;
      if (reset) begin
         pc_next_if_o = RESET_PC;
      end else if (state == CF_JALR_EX) begin
         pc_sel        = PC_ALU;
         pc_next_if_o  = jalr_target;
         pc_en_o       = 1'b1;
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
`ifdef CF_MISALIGN_TRAP_EN
         if (jalr_target[1]) begin
            pc_sel       = PC_TRAP;
            pc_next_if_o = TRAP_VECTOR;
            misalign     = 1'b1;
         end
`endif
      end else if (stall_i) begin
         id_ex_flush_o = 1'b1;
      end else if (jalr_id) begin
         pc_en_o = 1'b1;
      end else if (jal_id || br_taken) begin
         pc_sel        = PC_BRADD;
         pc_next_if_o  = branch_adder_id_i;
         pc_en_o       = 1'b1;
         if_id_flush_o = 1'b1;
`ifdef CF_MISALIGN_TRAP_EN
         if (branch_adder_id_i[1:0] != 2'b00) begin
            pc_sel       = PC_TRAP;
            pc_next_if_o = TRAP_VECTOR;
            misalign     = 1'b1;
         end
`endif
      end else begin
         pc_en_o = 1'b1;
      end
   end

   assign pc_sel_o       = pc_sel;
   assign jalr_pending_o = !reset && (state == CF_JALR_EX);

`ifdef CF_MISALIGN_TRAP_EN
   assign misalign_o = misalign;
`else
   logic unused_misalign;
   assign unused_misalign = misalign;
`endif

endmodule

// File: tb/tb_control_flow_ctrl.sv
// Self-checking bench for control_flow_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the next-PC/flush rules.
module tb_control_flow_ctrl;

   localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_TB = 32'h0000_0100;

   logic        clk;
   logic        reset;
   logic [31:0] instruction_id_i;
   logic        instruction_id_valid_i;
   logic        branch_condition_i;
   logic [31:0] branch_adder_id_i;
   logic [31:0] alu_result_ex_i;
   logic [31:0] pc_plus4_if_i;
   logic        stall_i;
   logic [31:0] pc_next_if_o;
   logic [1:0]  pc_sel_o;
   logic        pc_en_o;
   logic        if_id_flush_o;
   logic        id_ex_flush_o;
   logic        jalr_pending_o;
   logic        misalign_obs;

   int total = 0;
   int bad   = 0;

   // Model memory: the previous cycle left a JALR waiting for its EX target.
   bit jalrOwed = 1'b0;

   control_flow_ctrl dut (
      .clk                    (clk),
      .reset                  (reset),
      .instruction_id_i       (instruction_id_i),
      .instruction_id_valid_i (instruction_id_valid_i),
      .branch_condition_i     (branch_condition_i),
      .branch_adder_id_i      (branch_adder_id_i),
      .alu_result_ex_i        (alu_result_ex_i),
      .pc_plus4_if_i          (pc_plus4_if_i),
      .stall_i                (stall_i),
      .pc_next_if_o           (pc_next_if_o),
      .pc_sel_o               (pc_sel_o),
      .pc_en_o                (pc_en_o),
      .if_id_flush_o          (if_id_flush_o),
      .id_ex_flush_o          (id_ex_flush_o),
`ifdef CF_MISALIGN_TRAP_EN
      .misalign_o             (misalign_obs),
`endif
      .jalr_pending_o         (jalr_pending_o)
   );

`ifndef CF_MISALIGN_TRAP_EN
   assign misalign_obs = 1'b0;
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [31:0] eNext, input logic [1:0] eSel,
                           input logic eEn, input logic eIf, input logic eEx,
                           input logic ePend, input logic eMis);
      checkOutput({tag, ".pc_next"}, pc_next_if_o, eNext);
      checkOutput({tag, ".pc_sel"}, {30'd0, pc_sel_o}, {30'd0, eSel});
      checkOutput({tag, ".pc_en"}, {31'd0, pc_en_o}, {31'd0, eEn});
      checkOutput({tag, ".if_id_flush"}, {31'd0, if_id_flush_o}, {31'd0, eIf});
      checkOutput({tag, ".id_ex_flush"}, {31'd0, id_ex_flush_o}, {31'd0, eEx});
      checkOutput({tag, ".jalr_pending"}, {31'd0, jalr_pending_o}, {31'd0, ePend});
`ifdef CF_MISALIGN_TRAP_EN
      checkOutput({tag, ".misalign"}, {31'd0, misalign_obs}, {31'd0, eMis});
`else
      if (eMis) checkOutput({tag, ".misalign_expect"}, 32'd0, 32'd1);
`endif
   endtask

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input logic rst, input logic valid, input logic [31:0] instr,
                                input logic cond, input logic [31:0] adder, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic stall);
      @(posedge clk);
      #1;
      reset                  = rst;
      instruction_id_valid_i = valid;
      instruction_id_i       = instr;
      branch_condition_i     = cond;
      branch_adder_id_i      = adder;
      alu_result_ex_i        = alu;
      pc_plus4_if_i          = pc4;
      stall_i                = stall;
   endtask

   // Behavioural rules: what the PC logic must do this cycle given the inputs
   // and whether a JALR from last cycle is owed its EX-stage target.
   function automatic void modelOut(output logic [31:0] eNext, output logic [1:0] eSel,
                                    output logic eEn, output logic eIf, output logic eEx,
                                    output logic ePend, output logic eMis);
      logic [6:0]  opc;
      logic        isJal, isJalr, isBr, taken;
      logic [31:0] tgt;
      bit          trapOn;
`ifdef CF_MISALIGN_TRAP_EN
      trapOn = 1'b1;
`else
      trapOn = 1'b0;
`endif
      opc    = instruction_id_i[6:0];
      isJal  = instruction_id_valid_i && opc == 7'h6F;
      isJalr = instruction_id_valid_i && opc == 7'h67;
      isBr   = instruction_id_valid_i && opc == 7'h63;
      taken  = isBr && (instruction_id_i[12] ? !branch_condition_i : branch_condition_i);
      eNext = pc_plus4_if_i; eSel = 2'd0; eEn = 1'b1; eIf = 1'b0; eEx = 1'b0;
      ePend = 1'b0; eMis = 1'b0;
      if (reset) begin
         eNext = RESET_PC_TB; eEn = 1'b0;
      end else if (jalrOwed) begin
         tgt = alu_result_ex_i & 32'hFFFF_FFFE;
         ePend = 1'b1; eIf = 1'b1; eEx = 1'b1;
         if (trapOn && tgt[1]) begin eNext = TRAP_VEC_TB; eSel = 2'd3; eMis = 1'b1; end
         else begin eNext = tgt; eSel = 2'd2; end
      end else if (stall_i) begin
         eEn = 1'b0; eEx = 1'b1;
      end else if (isJalr) begin
         eEn = 1'b1;
      end else if (isJal || taken) begin
         eIf = 1'b1;
         if (trapOn && (branch_adder_id_i % 4) != 0) begin eNext = TRAP_VEC_TB; eSel = 2'd3; eMis = 1'b1; end
         else begin eNext = branch_adder_id_i; eSel = 2'd1; end
      end
   endfunction

   // Model memory update: a JALR seen unstalled in ID (outside a pending
   // JALR cycle) is owed its redirect on the following cycle.
   always @(posedge clk) begin
      jalrOwed <= !reset && !jalrOwed && !stall_i && instruction_id_valid_i &&
                  instruction_id_i[6:0] == 7'h67;
   end

   // Compare process: every cycle, DUT outputs against the model.
   always @(negedge clk) begin
      logic [31:0] eNext;
      logic [1:0]  eSel;
      logic        eEn, eIf, eEx, ePend, eMis;
      modelOut(eNext, eSel, eEn, eIf, eEx, ePend, eMis);
      checkAll("model", eNext, eSel, eEn, eIf, eEx, ePend, eMis);
   end

   initial begin
      logic [6:0]  opcTab [5];
      logic [6:0]  opc;
      logic [31:0] instr;
      logic [31:0] adder;
      logic [31:0] alu;
      opcTab[0] = 7'h6F; opcTab[1] = 7'h67; opcTab[2] = 7'h63;
      opcTab[3] = 7'h33; opcTab[4] = 7'h13;

      reset = 1'b1; instruction_id_valid_i = 1'b0; instruction_id_i = 32'd0;
      branch_condition_i = 1'b0; branch_adder_id_i = 32'd0; alu_result_ex_i = 32'd0;
      pc_plus4_if_i = 32'h0000_0004; stall_i = 1'b0;

      $display("[TB] directed phase");
      applyStimulus(1, 0, 32'd0, 0, 32'd0, 32'd0, 32'h4, 0);
      applyStimulus(1, 0, 32'd0, 0, 32'd0, 32'd0, 32'h4, 0);
      #1 checkAll("reset", 32'h0, 2'd0, 0, 0, 0, 0, 0);

      applyStimulus(0, 0, 32'h0000_006F, 0, 32'h40, 32'd0, 32'h104, 0);
      #1 checkAll("bubble", 32'h104, 2'd0, 1, 0, 0, 0, 0);

      applyStimulus(0, 1, 32'h0400_006F, 0, 32'h40, 32'd0, 32'h108, 0);
      #1 checkAll("jal", 32'h40, 2'd1, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 32'd0, 0, 32'h0, 32'd0, 32'h44, 0);
      #1 checkAll("after_jal", 32'h44, 2'd0, 1, 0, 0, 0, 0);

      applyStimulus(0, 1, 32'h0000_1063, 0, 32'h80, 32'd0, 32'h48, 0);
      #1 checkAll("bne_taken", 32'h80, 2'd1, 1, 1, 0, 0, 0);
      applyStimulus(0, 1, 32'h0000_0063, 0, 32'h80, 32'd0, 32'h84, 0);
      #1 checkAll("beq_not_taken", 32'h84, 2'd0, 1, 0, 0, 0, 0);

      applyStimulus(0, 1, 32'h0000_0067, 0, 32'h0, 32'd0, 32'h88, 0);
      #1 checkAll("jalr_arm", 32'h88, 2'd0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h0400_006F, 0, 32'h40, 32'h1235, 32'h8C, 0);
      #1 checkAll("jalr_ex", 32'h1234, 2'd2, 1, 1, 1, 1, 0);
      applyStimulus(0, 0, 32'd0, 0, 32'h0, 32'd0, 32'h1238, 0);
      #1 checkAll("jalr_back_run", 32'h1238, 2'd0, 1, 0, 0, 0, 0);

      applyStimulus(0, 1, 32'h0000_0067, 0, 32'h0, 32'd0, 32'h200, 1);
      #1 checkAll("jalr_stall1", 32'h200, 2'd0, 0, 0, 1, 0, 0);
      applyStimulus(0, 1, 32'h0000_0067, 0, 32'h0, 32'd0, 32'h200, 1);
      #1 checkAll("jalr_stall2", 32'h200, 2'd0, 0, 0, 1, 0, 0);
      applyStimulus(0, 1, 32'h0000_0067, 0, 32'h0, 32'd0, 32'h200, 0);
      #1 checkAll("jalr_unstall", 32'h200, 2'd0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h0000_0067, 0, 32'h0, 32'h3000, 32'h204, 1);
      #1 checkAll("jalr_b2b_ex", 32'h3000, 2'd2, 1, 1, 1, 1, 0);
      applyStimulus(0, 0, 32'd0, 0, 32'h0, 32'd0, 32'h3004, 0);
      #1 checkAll("jalr_b2b_not_armed", 32'h3004, 2'd0, 1, 0, 0, 0, 0);

      applyStimulus(0, 1, 32'h0000_0067, 0, 32'h0, 32'd0, 32'h400, 0);
      applyStimulus(1, 0, 32'd0, 0, 32'h0, 32'h5000, 32'h404, 0);
      #1 checkAll("reset_mid_jalr", 32'h0, 2'd0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 32'd0, 0, 32'h0, 32'h5000, 32'h4, 0);
      #1 checkAll("after_reset_mid", 32'h4, 2'd0, 1, 0, 0, 0, 0);

      applyStimulus(0, 1, 32'h0000_006F, 0, 32'h42, 32'd0, 32'h8, 0);
`ifdef CF_MISALIGN_TRAP_EN
      #1 checkAll("jal_misaligned", 32'h100, 2'd3, 1, 1, 0, 0, 1);
`else
      #1 checkAll("jal_misaligned", 32'h42, 2'd1, 1, 1, 0, 0, 0);
`endif

      $display("[TB] random phase");
      for (int i = 0; i < 2000; i++) begin
         opc   = opcTab[$urandom_range(0, 4)];
         instr = {$urandom} & 32'hFFFF_FF80;
         instr = instr | {25'd0, opc};
         adder = $urandom;
         alu   = $urandom;
         if ($urandom_range(0, 1) == 0) adder = adder & 32'hFFFF_FFFC;
         if ($urandom_range(0, 1) == 0) alu = alu & 32'hFFFF_FFFD;
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0, instr,
                       1'($urandom_range(0, 1)), adder, alu, $urandom,
                       $urandom_range(0, 3) == 0);
      end
      applyStimulus(0, 0, 32'd0, 0, 32'd0, 32'd0, 32'h4, 0);
      @(posedge clk);
      #6;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
